// File: rtl/if_prefetch_unit_if.sv
// Fetch-side bus bundle: memory request/response, redirect and decode-side instruction handshake.
interface if_prefetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic [31:0]       inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        output mem_req_valid, mem_req_addr, inst_valid, inst_out, inst_pc,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, inst_valid, inst_out, inst_pc,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/if_prefetch_unit.sv
// Instruction prefetcher: issues sequential fetches, buffers returned words with their PCs,
// and drops responses for requests that were in flight when a redirect happened.
module if_prefetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    if_prefetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [31:0]       fifo_data [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     fifo_count;
    logic [ADDR_W-1:0] opc [DEPTH];
    logic [PW-1:0]     o_rd, o_wr;
    logic [CW-1:0]     outstanding, out_next;
    logic [CW-1:0]     drop_cnt, drop_next;
    logic              req_fire, rsp_fire, discard, push, pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Buffer slots plus in-flight requests never exceed DEPTH, so the FIFO cannot overflow.
    assign bus.mem_req_valid = !reset &&
        (({1'b0, fifo_count} + {1'b0, outstanding}) < (CW + 1)'(DEPTH));
    assign bus.mem_req_addr  = fetch_pc;
    assign bus.inst_valid    = !reset && (fifo_count != '0);
    assign bus.inst_out      = fifo_data[rd_ptr];
    assign bus.inst_pc       = fifo_pc[rd_ptr];

    assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
    assign rsp_fire = bus.mem_rsp_valid && (outstanding != '0);
    assign discard  = (state == FLUSH) || bus.redirect_valid;
    assign push     = rsp_fire && !discard;
    assign pop      = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
    assign out_next = outstanding + CW'(req_fire) - CW'(rsp_fire);

    always_comb begin
        drop_next = drop_cnt;
        if (bus.redirect_valid)
            drop_next = out_next;
        else if (rsp_fire && state == FLUSH)
            drop_next = drop_cnt - CW'(1);
        state_next = (drop_next != '0) ? FLUSH : RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            o_rd        <= '0;
            o_wr        <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            if (bus.redirect_valid)
                fetch_pc <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            else if (req_fire)
                fetch_pc <= fetch_pc + ADDR_W'(4);
            // The request-PC queue keeps popping on stale responses so it stays aligned.
            if (req_fire) o_wr <= inc(o_wr);
            if (rsp_fire) o_rd <= inc(o_rd);
            outstanding <= out_next;
            drop_cnt    <= drop_next;
            if (bus.redirect_valid) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push) wr_ptr <= inc(wr_ptr);
                if (pop)  rd_ptr <= inc(rd_ptr);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) opc[o_wr] <= fetch_pc;
        if (push) begin
            fifo_data[wr_ptr] <= bus.mem_rsp_data;
            fifo_pc[wr_ptr]   <= opc[o_rd];
        end
    end
endmodule

// File: doc/if_prefetch_unit.md
IF_PREFETCH_UNIT -- requirements
Module: if_prefetch_unit

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 8, width of the PC and fetch address.
- DEPTH, 4, instruction buffer entries and maximum outstanding requests.
- RESET_PC, 0, first fetch address after reset.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- mem_req_valid  out  1  fetch request valid.
- mem_req_addr  out  ADDR_W  fetch byte address.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_rsp_valid  in  1  instruction word returned this cycle; responses arrive in request order.
- mem_rsp_data  in  32  returned instruction word.
- redirect_valid  in  1  branch/jump taken; restart fetch.
- redirect_pc  in  ADDR_W  new fetch address.
- inst_valid  out  1  inst_out/inst_pc valid.
- inst_out  out  32  instruction to decode/register-file stage.
- inst_pc  out  ADDR_W  address of inst_out.
- inst_ready  in  1  downstream consumes the head instruction this cycle.

REQ-003 Reset SHALL be synchronous, active-high, sampled on the rising edge of clk; there SHALL be one clock domain.

Function
REQ-004 A request SHALL be accepted only in a cycle where mem_req_valid and mem_req_ready are both 1.
REQ-005 A response SHALL be accepted in any cycle where mem_rsp_valid is 1; mem_rsp_valid with zero outstanding requests SHALL be ignored.
REQ-006 Internal state:
- fetch_pc (ADDR_W).
- FIFO of DEPTH {data, pc} entries and its count.
- outstanding counter (0..DEPTH).
- drop counter (0..DEPTH).
- FIFO of outstanding request PCs.
REQ-007 mem_req_valid SHALL be 1 when not in reset and fifo_count + outstanding < DEPTH; mem_req_addr SHALL equal fetch_pc.
REQ-008 On request acceptance, fetch_pc SHALL advance by 4 modulo 2^ADDR_W; the wrap 0xFC -> 0x00 is legal for ADDR_W=8.
REQ-009 A response accepted while drop counter = 0 SHALL be pushed into the FIFO with its request PC. A response accepted while drop counter > 0 SHALL be discarded and the drop counter decremented.
REQ-010 The state machine SHALL have states:
- RUN: drop counter = 0.
- FLUSH: drop counter > 0.
- FLUSH -> RUN when the last stale response is discarded.
- Requests SHALL continue to issue in FLUSH, subject to REQ-007.
REQ-011 inst_valid SHALL be 1 when fifo_count > 0; inst_out/inst_pc SHALL show the FIFO head; the head SHALL pop when inst_valid and inst_ready are both 1.
REQ-012 The FIFO SHALL be registered, with no response-to-output bypass: a response accepted in cycle N SHALL appear on inst_out no earlier than cycle N+1. The minimum request-accept to inst_valid latency SHALL be 2 cycles when memory responds the cycle after acceptance.
REQ-013 Push and pop in the same cycle SHALL leave fifo_count unchanged; full-FIFO overflow SHALL be impossible by REQ-007.
REQ-014 On redirect_valid, in the same edge:
- fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
- FIFO flushed, so inst_valid = 0 next cycle.
- drop counter <= outstanding after this cycle's request/response updates.
- The state enters FLUSH if that value is > 0.
REQ-015 Simultaneous events with redirect_valid:
- A pop in the same cycle SHALL be void.
- A request accepted in the same cycle SHALL count as stale.
- A response accepted in the same cycle SHALL be discarded and not counted.
REQ-016 After a redirect, mem_req_addr MAY change while mem_req_valid = 1 without prior acceptance; memory SHALL treat each cycle's handshake independently.
REQ-017 inst_pc of every delivered instruction SHALL equal the address of the request that produced it.

Reset
REQ-018 While reset = 1, the next edge SHALL set:
- fetch_pc = RESET_PC.
- All counters and FIFOs empty; state = RUN.
- mem_req_valid = 0 and inst_valid = 0 throughout the reset cycle.
REQ-019 Reset asserted mid-operation SHALL discard all buffered and outstanding fetches; responses for pre-reset requests are the memory's responsibility to suppress.
REQ-020 In the first cycle after reset deassertion, mem_req_valid SHALL be 1 with mem_req_addr = RESET_PC.

Verification
REQ-021 Streaming: mem_req_ready = 1, responses 1 cycle after acceptance, inst_ready = 1 -> inst_pc sequence 0x00, 0x04, 0x08..., with inst_valid first high 2 cycles after the first acceptance.
REQ-022 Backpressure: inst_ready = 0 -> exactly 4 requests accepted (0x00..0x0C), then mem_req_valid = 0. Raising inst_ready for 1 cycle -> one pop, then one new request at 0x10.
REQ-023 Redirect with 3 outstanding: redirect_pc = 0x40 -> the next 3 responses are discarded, the first delivered instruction has inst_pc = 0x40, and the state returns to RUN.
REQ-024 Redirect, pop and response in the same cycle: redirect_pc = 0x23 -> fetch restarts at 0x20, the response is discarded, and inst_valid = 0 the next cycle.
REQ-025 Wrap and reset: sequential fetch from 0xF8 yields 0xF8, 0xFC, 0x00. Asserting reset mid-stream -> both FIFOs and all counters empty after the reset cycle, and the first request after deassertion is at RESET_PC.
